// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM-stage data-cache miss controller.
//   miss_state_e    : controller states (IDLE, LOOKUP1, WB, RF, REPLAY)
//   MEM_LATENCY_DEF : default main-memory latency per writeback or refill
//   LANE0 / LANE1   : lane index values carried on sel_lane_mem
package pipeline_pkg;

    localparam int MEM_LATENCY_DEF = 20;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP1,
        WB,
        RF,
        REPLAY
    } miss_state_e;

endpackage

// File: rtl/dcache_miss_ctrl_mem_latency_counter.sv
// Main-memory latency counter shared by the writeback and refill phases.
// Ports:
//   clk    in  clock, rising edge
//   clear  in  synchronous clear to 0 (dominates enable)
//   enable in  count this cycle
//   cnt    out current count, 0..MEM_LATENCY-1
//   last   out cnt is at MEM_LATENCY-1 (final cycle of a transfer)
module mem_latency_counter #(
    parameter int MEM_LATENCY = 20,
    parameter int CNT_W       = $clog2(MEM_LATENCY)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    assign last = (cnt == CNT_W'(MEM_LATENCY - 1));

    // Wraps to 0 on the final cycle so the next phase starts from a clean count.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// MEM-stage data-cache port controller for the dual-issue pipeline.
// Serialises lane0/lane1 accesses onto the single cache port and sequences
// dirty-victim writeback plus line refill against fixed-latency main memory.
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   memread0_mem, memwrite0_mem   lane0 load / store in MEM
//   memread1_mem, memwrite1_mem   lane1 load / store in MEM
//   cache_hit_mem                 tag hit for the lane on sel_lane_mem
//   valid_dirty_mem               victim line is valid and dirty
//   sel_lane_mem                  lane driving the cache port
//   stall_latch_mem               hold IF/ID/EXE/MEM, flush WB
//   cache_we_mem                  commit store of the selected lane
//   refill_we_mem                 one-cycle pulse writing the fetched line
//   mainmem_read / mainmem_write  refill / writeback in progress
module dcache_miss_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int CNT_W       = $clog2(MEM_LATENCY)
) (
    input  logic clk,
    input  logic reset,
    input  logic memread0_mem,
    input  logic memwrite0_mem,
    input  logic memread1_mem,
    input  logic memwrite1_mem,
    input  logic cache_hit_mem,
    input  logic valid_dirty_mem,
    output logic sel_lane_mem,
    output logic stall_latch_mem,
    output logic cache_we_mem,
    output logic refill_we_mem,
    output logic mainmem_read,
    output logic mainmem_write
);

    miss_state_e      state, state_nxt;
    logic             cur_lane, cur_lane_nxt;
    logic             lane1_pend, lane1_pend_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             mem_busy;
    logic             acc0, acc1;
    miss_state_e      miss_target;

    assign acc0        = memread0_mem | memwrite0_mem;
    assign acc1        = memread1_mem | memwrite1_mem;
    assign miss_target = valid_dirty_mem ? WB : RF;
    assign mem_busy    = (state == WB) || (state == RF);

    // Outside WB/RF the counter is held clear so it always starts a transfer at 0.
    mem_latency_counter #(
        .MEM_LATENCY(MEM_LATENCY),
        .CNT_W      (CNT_W)
    ) u_lat_cnt (
        .clk    (clk),
        .clear  (reset | ~mem_busy),
        .enable (mem_busy),
        .cnt    (cnt),
        .last   (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur_lane   <= LANE0;
            lane1_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_lane   <= cur_lane_nxt;
            lane1_pend <= lane1_pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ({1'b0, cnt} < (CNT_W + 1)'(MEM_LATENCY));
        end
    end

    always_comb begin
        state_nxt       = state;
        cur_lane_nxt    = cur_lane;
        lane1_pend_nxt  = lane1_pend;
        sel_lane_mem    = LANE0;
        stall_latch_mem = 1'b0;
        cache_we_mem    = 1'b0;
        refill_we_mem   = 1'b0;
        mainmem_read    = 1'b0;
        mainmem_write   = 1'b0;

        // While reset is high every output stays low; the registers reload on the edge.
        if (!reset) begin
            case (state)
                IDLE: begin
                    sel_lane_mem = acc0 ? LANE0 : LANE1;
                    if (acc0 || acc1) begin
                        if (!cache_hit_mem) begin
                            stall_latch_mem = 1'b1;
                            cur_lane_nxt    = sel_lane_mem;
                            lane1_pend_nxt  = acc0 & acc1;
                            state_nxt       = miss_target;
                        end else if (acc0 && acc1) begin
                            // Lane0 hit commits now; lane1 gets its own lookup next cycle.
                            stall_latch_mem = 1'b1;
                            cache_we_mem    = memwrite0_mem;
                            state_nxt       = LOOKUP1;
                        end else begin
                            cache_we_mem = acc0 ? memwrite0_mem : memwrite1_mem;
                        end
                    end
                end

                LOOKUP1: begin
                    sel_lane_mem = LANE1;
                    if (cache_hit_mem) begin
                        cache_we_mem = memwrite1_mem;
                        state_nxt    = IDLE;
                    end else begin
                        stall_latch_mem = 1'b1;
                        cur_lane_nxt    = LANE1;
                        lane1_pend_nxt  = 1'b0;
                        state_nxt       = miss_target;
                    end
                end

                WB: begin
                    sel_lane_mem    = cur_lane;
                    stall_latch_mem = 1'b1;
                    mainmem_write   = 1'b1;
                    if (cnt_last) begin
                        state_nxt = RF;
                    end
                end

                RF: begin
                    sel_lane_mem    = cur_lane;
                    stall_latch_mem = 1'b1;
                    mainmem_read    = 1'b1;
                    if (cnt_last) begin
                        refill_we_mem = 1'b1;
                        state_nxt     = REPLAY;
                    end
                end

                REPLAY: begin
                    sel_lane_mem = cur_lane;
                    if (cache_hit_mem) begin
                        cache_we_mem = (cur_lane == LANE1) ? memwrite1_mem : memwrite0_mem;
                        if (lane1_pend) begin
                            stall_latch_mem = 1'b1;
                            lane1_pend_nxt  = 1'b0;
                            state_nxt       = LOOKUP1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        // Refilled line was lost; fetch it again, keeping lane1_pend.
                        stall_latch_mem = 1'b1;
                        state_nxt       = miss_target;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Testbench for dcache_miss_ctrl: reset checks, a table of single-cycle
// IDLE vectors, directed multi-cycle scenarios and randomized access bundles
// compared against a per-lane transaction model.
module tb_dcache_miss_ctrl;

    localparam int ML = 20;

    logic clk = 1'b0;
    logic reset;
    logic memread0_mem, memwrite0_mem, memread1_mem, memwrite1_mem;
    logic cache_hit_mem, valid_dirty_mem;
    logic sel_lane_mem, stall_latch_mem, cache_we_mem, refill_we_mem;
    logic mainmem_read, mainmem_write;

    always #5 clk = ~clk;

    dcache_miss_ctrl #(.MEM_LATENCY(ML)) dut (
        .clk             (clk),
        .reset           (reset),
        .memread0_mem    (memread0_mem),
        .memwrite0_mem   (memwrite0_mem),
        .memread1_mem    (memread1_mem),
        .memwrite1_mem   (memwrite1_mem),
        .cache_hit_mem   (cache_hit_mem),
        .valid_dirty_mem (valid_dirty_mem),
        .sel_lane_mem    (sel_lane_mem),
        .stall_latch_mem (stall_latch_mem),
        .cache_we_mem    (cache_we_mem),
        .refill_we_mem   (refill_we_mem),
        .mainmem_read    (mainmem_read),
        .mainmem_write   (mainmem_write)
    );

    int vectors     = 0;
    int miscompares = 0;

    // One expected clock cycle: inputs to drive and the outputs required.
    typedef struct {
        logic hit;
        logic dirty;
        logic sel;
        logic sel_care;
        logic stall;
        logic we;
        logic rwe;
        logic mr;
        logic mw;
    } cyc_t;

    cyc_t exp_q[$];

    // Single-cycle vectors applied from IDLE that return to IDLE.
    typedef struct {
        logic m0r, m0w, m1r, m1w, hit, dirty;
        logic sel, stall, we;
    } vec_t;

    vec_t tbl[7];

    task automatic check_cycle(input string name, input int idx,
                               input logic e_sel, input logic e_sel_care, input logic e_stall,
                               input logic e_we, input logic e_rwe, input logic e_mr, input logic e_mw,
                               output logic o_stall, output logic o_we, output logic o_rwe,
                               output logic o_mr, output logic o_mw);
        @(negedge clk);
        vectors++;
        o_stall = stall_latch_mem;
        o_we    = cache_we_mem;
        o_rwe   = refill_we_mem;
        o_mr    = mainmem_read;
        o_mw    = mainmem_write;
        if (stall_latch_mem !== e_stall || cache_we_mem !== e_we || refill_we_mem !== e_rwe ||
            mainmem_read !== e_mr || mainmem_write !== e_mw ||
            (e_sel_care && sel_lane_mem !== e_sel)) begin
            miscompares++;
            $display("FAIL %s[%0d]: got sel=%b stall=%b we=%b rwe=%b mr=%b mw=%b, want sel=%b(care=%b) stall=%b we=%b rwe=%b mr=%b mw=%b",
                     name, idx, sel_lane_mem, stall_latch_mem, cache_we_mem, refill_we_mem,
                     mainmem_read, mainmem_write, e_sel, e_sel_care, e_stall, e_we, e_rwe, e_mr, e_mw);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Expected trace for one lane: each attempt is a lookup; a miss costs an
    // optional ML-cycle writeback plus an ML-cycle refill before the next attempt.
    // The pipeline advances only on the final hit of the last lane.
    task automatic push_lane(input logic lane, input logic wr, input logic last_lane,
                             input int misses, input logic [3:0] dmask);
        cyc_t c;
        for (int a = 0; a <= misses; a++) begin
            c = '{default: 1'b0};
            c.sel      = lane;
            c.sel_care = 1'b1;
            if (a == misses) begin
                c.hit   = 1'b1;
                c.dirty = 1'($urandom);
                c.stall = !last_lane;
                c.we    = wr;
                exp_q.push_back(c);
            end else begin
                c.hit   = 1'b0;
                c.dirty = dmask[a];
                c.stall = 1'b1;
                exp_q.push_back(c);
                if (dmask[a]) begin
                    for (int i = 0; i < ML; i++) begin
                        c = '{default: 1'b0};
                        c.hit   = 1'($urandom);
                        c.dirty = 1'($urandom);
                        c.stall = 1'b1;
                        c.mw    = 1'b1;
                        exp_q.push_back(c);
                    end
                end
                for (int i = 0; i < ML; i++) begin
                    c = '{default: 1'b0};
                    c.hit   = 1'($urandom);
                    c.dirty = 1'($urandom);
                    c.stall = 1'b1;
                    c.mr    = 1'b1;
                    c.rwe   = (i == ML - 1);
                    exp_q.push_back(c);
                end
            end
        end
    endtask

    // kind: 0 = no access, 1 = load, 2 = store.
    task automatic run_bundle(input string name, input int k0, input int k1,
                              input int miss0, input int miss1,
                              input logic [3:0] d0, input logic [3:0] d1,
                              output int stalls, output int rwes, output int wes,
                              output int mrs, output int mws);
        logic acc0, acc1;
        logic o_stall, o_we, o_rwe, o_mr, o_mw;
        cyc_t c;
        acc0 = (k0 != 0);
        acc1 = (k1 != 0);
        exp_q.delete();
        if (!acc0 && !acc1) begin
            c = '{default: 1'b0};
            c.hit      = 1'($urandom);
            c.dirty    = 1'($urandom);
            c.sel      = 1'b1;
            c.sel_care = 1'b1;
            exp_q.push_back(c);
        end
        if (acc0) push_lane(1'b0, k0 == 2, !acc1, miss0, d0);
        if (acc1) push_lane(1'b1, k1 == 2, 1'b1, miss1, d1);
        memread0_mem  = (k0 == 1);
        memwrite0_mem = (k0 == 2);
        memread1_mem  = (k1 == 1);
        memwrite1_mem = (k1 == 2);
        stalls = 0; rwes = 0; wes = 0; mrs = 0; mws = 0;
        foreach (exp_q[i]) begin
            cache_hit_mem   = exp_q[i].hit;
            valid_dirty_mem = exp_q[i].dirty;
            check_cycle(name, i, exp_q[i].sel, exp_q[i].sel_care, exp_q[i].stall, exp_q[i].we,
                        exp_q[i].rwe, exp_q[i].mr, exp_q[i].mw,
                        o_stall, o_we, o_rwe, o_mr, o_mw);
            if (o_stall) stalls++;
            if (o_rwe)   rwes++;
            if (o_we)    wes++;
            if (o_mr)    mrs++;
            if (o_mw)    mws++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int st, rw, we, mr, mw;
        logic o_stall, o_we, o_rwe, o_mr, o_mw;
        int r, k0, k1, m0, m1;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset with an access pending: every output must stay low.
        reset = 1'b1;
        memread0_mem = 1'b1; memwrite0_mem = 1'b0;
        memread1_mem = 1'b0; memwrite1_mem = 1'b1;
        cache_hit_mem = 1'b0; valid_dirty_mem = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            check_cycle("reset", i, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                        o_stall, o_we, o_rwe, o_mr, o_mw);
        reset = 1'b0;

        // Table of single-cycle IDLE vectors.
        for (int i = 0; i < 7; i++) begin
            memread0_mem    = tbl[i].m0r;
            memwrite0_mem   = tbl[i].m0w;
            memread1_mem    = tbl[i].m1r;
            memwrite1_mem   = tbl[i].m1w;
            cache_hit_mem   = tbl[i].hit;
            valid_dirty_mem = tbl[i].dirty;
            check_cycle("table", i, tbl[i].sel, 1'b1, tbl[i].stall, tbl[i].we, 1'b0, 1'b0, 1'b0,
                        o_stall, o_we, o_rwe, o_mr, o_mw);
        end

        // Lane0 load hits repeatedly, lane1 idle.
        for (int i = 0; i < 3; i++) begin
            run_bundle("l0_load_hit", 1, 0, 0, 0, 4'b0, 4'b0, st, rw, we, mr, mw);
            check_int("l0_load_hit_stalls", st, 0);
        end

        // Lane0 store + lane1 load, both hit.
        run_bundle("dual_hit", 2, 1, 0, 0, 4'b0, 4'b0, st, rw, we, mr, mw);
        check_int("dual_hit_stalls", st, 1);
        check_int("dual_hit_we", we, 1);

        // Lane0 load, clean miss.
        run_bundle("l0_clean_miss", 1, 0, 1, 0, 4'b0000, 4'b0, st, rw, we, mr, mw);
        check_int("l0_clean_miss_stalls", st, 1 + ML);
        check_int("l0_clean_miss_mr", mr, ML);
        check_int("l0_clean_miss_rwe", rw, 1);

        // Lane1 store, dirty victim.
        run_bundle("l1_dirty_miss", 0, 2, 0, 1, 4'b0, 4'b0001, st, rw, we, mr, mw);
        check_int("l1_dirty_miss_stalls", st, 1 + 2 * ML);
        check_int("l1_dirty_miss_mw", mw, ML);
        check_int("l1_dirty_miss_mr", mr, ML);
        check_int("l1_dirty_miss_we", we, 1);

        // Both lanes load, both clean misses.
        run_bundle("both_miss", 1, 1, 1, 1, 4'b0000, 4'b0000, st, rw, we, mr, mw);
        check_int("both_miss_stalls", st, 2 * (1 + ML) + 1);
        check_int("both_miss_rwe", rw, 2);

        // Refill lost once in replay, with a dirty line on the retry.
        run_bundle("replay_miss", 2, 2, 2, 0, 4'b0010, 4'b0000, st, rw, we, mr, mw);
        check_int("replay_miss_stalls", st, 3 + 3 * ML);
        check_int("replay_miss_we", we, 2);

        // Reset on the tenth refill cycle abandons the transfer.
        memread0_mem = 1'b1; memwrite0_mem = 1'b0;
        memread1_mem = 1'b0; memwrite1_mem = 1'b0;
        cache_hit_mem = 1'b0; valid_dirty_mem = 1'b0;
        check_cycle("rst_rf_lookup", 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    o_stall, o_we, o_rwe, o_mr, o_mw);
        for (int i = 0; i < 9; i++) begin
            cache_hit_mem = 1'($urandom);
            check_cycle("rst_rf_fill", i, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                        o_stall, o_we, o_rwe, o_mr, o_mw);
        end
        reset = 1'b1;
        check_cycle("rst_rf_reset", 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    o_stall, o_we, o_rwe, o_mr, o_mw);
        reset = 1'b0;
        memread0_mem = 1'b0;
        for (int i = 0; i < ML + 5; i++) begin
            cache_hit_mem   = 1'($urandom);
            valid_dirty_mem = 1'($urandom);
            check_cycle("rst_rf_idle", i, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                        o_stall, o_we, o_rwe, o_mr, o_mw);
        end
        run_bundle("post_reset_miss", 2, 0, 1, 0, 4'b0000, 4'b0, st, rw, we, mr, mw);
        check_int("post_reset_miss_stalls", st, 1 + ML);

        // Randomized bundles.
        for (int n = 0; n < 40; n++) begin
            k0 = $urandom_range(0, 2);
            k1 = $urandom_range(0, 2);
            r  = $urandom_range(0, 9);
            m0 = (r < 5) ? 0 : ((r < 8) ? 1 : 2);
            r  = $urandom_range(0, 9);
            m1 = (r < 5) ? 0 : ((r < 8) ? 1 : 2);
            run_bundle("rand", k0, k1, m0, m1, 4'($urandom), 4'($urandom), st, rw, we, mr, mw);
        end

        memread0_mem = 1'b0; memwrite0_mem = 1'b0;
        memread1_mem = 1'b0; memwrite1_mem = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
